ram_port_arbiter: RTL

- Shares one port of the team's dual-port RAM (wr_en/rd_en/addr/data_in/data_out port) between N requesters using round-robin arbitration.
- After reset it optionally clears the whole RAM to zero before it grants any requester.
- Read data returns tagged with the requester ID, one cycle after the RAM read.
- Sits between client logic and one RAM port; the other RAM port is untouched.

---
 rtl/ram_port_arbiter_pkg.sv | 21 ++
 rtl/ram_port_arbiter_rr_pick.sv | 39 +++
 rtl/ram_port_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter_pkg
// Brief    : Shared types and helpers for the RAM port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ram_port_arbiter_pkg;

    // Arbiter operating phase: zero-fill the RAM, then serve requesters.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker. Searches the request vector
//            upward from i_rr_ptr, wrapping at N_REQ-1, and returns a one-hot
//            grant, the winner index and an any-grant flag.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDW-1:0]   i_rr_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDW-1:0]   o_idx,
    output logic             o_any_gnt
);

    logic [IDW-1:0] w_cand;

    // First asserted request at or after the pointer wins.
    always_comb begin
        o_gnt     = '0;
        o_idx     = '0;
        o_any_gnt = 1'b0;
        w_cand    = '0;
        for (int off = 0; off < N_REQ; off++) begin
            w_cand = IDW'((int'(i_rr_ptr) + off) % N_REQ);
            if (!o_any_gnt && i_req[w_cand]) begin
                o_any_gnt     = 1'b1;
                o_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Brief    : Shares one RAM port between N_REQ requesters with round-robin
//            arbitration. Optionally zero-fills the RAM after reset, and
//            returns read data tagged with the requester index.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int DEPTH          = 256,
    parameter int CLEAR_ON_RESET = 1,
    localparam int IDW           = idx_width(N_REQ),
    localparam int AW            = idx_width(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            we,
    input  logic [N_REQ*AW-1:0]         addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]            gnt,
    output logic                        rvalid,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic [IDW-1:0]              rid,
    output logic                        busy,
    output logic                        ram_wr_en,
    output logic                        ram_rd_en,
    output logic [AW-1:0]               ram_addr,
    output logic [DATA_WIDTH-1:0]       ram_data_in,
    input  logic [DATA_WIDTH-1:0]       ram_data_out
);

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic            rvalid_q, rvalid_d;
    logic [IDW-1:0]  rid_q, rid_d;

    logic [N_REQ-1:0]      w_pick_gnt;
    logic [IDW-1:0]        w_win;
    logic                  w_any;
    logic                  w_win_we;
    logic [AW-1:0]         w_win_addr;
    logic [DATA_WIDTH-1:0] w_win_wdata;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr_pick (
        .i_req     (req),
        .i_rr_ptr  (rr_ptr_q),
        .o_gnt     (w_pick_gnt),
        .o_idx     (w_win),
        .o_any_gnt (w_any)
    );

    assign w_win_we    = we[w_win];
    assign w_win_addr  = addr[w_win*AW +: AW];
    assign w_win_wdata = wdata[w_win*DATA_WIDTH +: DATA_WIDTH];

    // The RAM registers its output, so rdata is taken straight from it and
    // qualified by the registered rvalid/rid of the read granted last cycle.
    assign rvalid = rvalid_q;
    assign rid    = rid_q;
    assign rdata  = ram_data_out;

    // Next-state, RAM port muxing and grant generation.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        rvalid_d    = 1'b0;
        rid_d       = rid_q;
        gnt         = '0;
        busy        = 1'b0;
        ram_wr_en   = 1'b0;
        ram_rd_en   = 1'b0;
        ram_addr    = '0;
        ram_data_in = '0;
        case (state_q)
            CLEAR: begin
                busy      = 1'b1;
                ram_wr_en = 1'b1;
                ram_addr  = clr_cnt_q;
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    clr_cnt_d = '0;
                    state_d   = RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (w_any) begin
                    gnt         = w_pick_gnt;
                    ram_wr_en   = w_win_we;
                    ram_rd_en   = ~w_win_we;
                    ram_addr    = w_win_addr;
                    ram_data_in = w_win_wdata;
                    rr_ptr_d    = (w_win == IDW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
                    if (!w_win_we) begin
                        rvalid_d = 1'b1;
                        rid_d    = w_win;
                    end
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // State, clear counter, fairness pointer and read-return pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RESET_STATE;
            clr_cnt_q <= '0;
            rr_ptr_q  <= '0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            rvalid_q  <= rvalid_d;
            rid_q     <= rid_d;
        end
    end

endmodule
`default_nettype wire
